// File: rtl/dram_burst_splitter_if.sv
// rtl/dram_burst_splitter_if.sv - AXI4 channel bundle used on both sides of the burst splitter
interface dram_burst_splitter_if #(
    parameter int IDW = 8,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic [IDW-1:0]  ARID;
    logic [AW-1:0]   ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [IDW-1:0]  RID;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    logic [IDW-1:0]  AWID;
    logic [AW-1:0]   AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;

    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [IDW-1:0]  BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY
    );
endinterface

// File: rtl/dram_burst_splitter.sv
// rtl/dram_burst_splitter.sv - splits AXI4 bursts into single-beat transactions and merges the responses
module dram_burst_splitter #(
    parameter int IDW = 8,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    dram_burst_splitter_if.slave   s_axi,
    dram_burst_splitter_if.master  m_axi
);
    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, WR_BACK
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_id;
    logic [AW-1:0]    r_addr;
    logic [3:0]       r_len;
    logic [2:0]       r_size;
    logic [1:0]       r_burst;
    logic [3:0]       r_cnt;
    logic [1:0]       r_bresp;
    logic             r_wlast;
    logic             r_err;

    logic             w_idle;
    logic             w_rd_data;
    logic             w_wr_data;
    logic             w_wr_back;
    logic             w_last_beat;
    logic [AW-1:0]    w_next_addr;
    logic             w_unused_ok;

    assign w_idle      = (r_state == IDLE);
    assign w_rd_data   = (r_state == RD_DATA);
    assign w_wr_data   = (r_state == WR_DATA);
    assign w_wr_back   = (r_state == WR_BACK);
    assign w_last_beat = (r_cnt == r_len);
    // FIXED keeps hammering one address; INCR and WRAP both step linearly because each beat is issued alone
    assign w_next_addr = (r_burst == 2'b00) ? r_addr : r_addr + (AW'(1) << r_size);
    assign w_unused_ok = ^{m_axi.RLAST, m_axi.RID, m_axi.BID};

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_bresp <= '0;
            r_wlast <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_bresp <= '0;
                    r_wlast <= 1'b0;
                    r_err   <= 1'b0;
                    if (s_axi.AWVALID) begin
                        r_id    <= s_axi.AWID;
                        r_addr  <= s_axi.AWADDR;
                        r_len   <= s_axi.AWLEN;
                        r_size  <= s_axi.AWSIZE;
                        r_burst <= s_axi.AWBURST;
                        r_state <= WR_ADDR;
                    end else if (s_axi.ARVALID) begin
                        r_id    <= s_axi.ARID;
                        r_addr  <= s_axi.ARADDR;
                        r_len   <= s_axi.ARLEN;
                        r_size  <= s_axi.ARSIZE;
                        r_burst <= s_axi.ARBURST;
                        r_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (m_axi.ARREADY) r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (m_axi.RVALID && s_axi.RREADY) begin
                        if (w_last_beat) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_addr  <= w_next_addr;
                            r_state <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR: begin
                    if (m_axi.AWREADY) r_state <= WR_DATA;
                end
                WR_DATA: begin
                    if (s_axi.WVALID && m_axi.WREADY) begin
                        r_wlast <= s_axi.WLAST;
                        r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi.BVALID) begin
                        r_bresp <= r_bresp | m_axi.BRESP;
                        if (w_last_beat || r_wlast) begin
                            // WLAST disagreeing with the announced length means the burst was malformed
                            r_err   <= (w_last_beat != r_wlast);
                            r_state <= WR_BACK;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_addr  <= w_next_addr;
                            r_state <= WR_ADDR;
                        end
                    end
                end
                WR_BACK: begin
                    if (s_axi.BREADY) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Upstream side: everything not owned by the current state is held at zero
    assign s_axi.AWREADY = w_idle & s_axi.AWVALID;
    assign s_axi.ARREADY = w_idle & s_axi.ARVALID & ~s_axi.AWVALID;

    assign s_axi.RVALID  = w_rd_data & m_axi.RVALID;
    assign s_axi.RDATA   = w_rd_data ? m_axi.RDATA : '0;
    assign s_axi.RRESP   = w_rd_data ? m_axi.RRESP : 2'b00;
    assign s_axi.RID     = w_rd_data ? r_id : '0;
    assign s_axi.RLAST   = w_rd_data & w_last_beat;

    assign s_axi.WREADY  = w_wr_data & m_axi.WREADY;

    assign s_axi.BVALID  = w_wr_back;
    assign s_axi.BID     = w_wr_back ? r_id : '0;
    assign s_axi.BRESP   = w_wr_back ? (r_err ? 2'b10 : r_bresp) : 2'b00;

    // Downstream side: every beat goes out as its own LEN=0 INCR transaction
    assign m_axi.ARVALID = (r_state == RD_ADDR);
    assign m_axi.ARID    = r_id;
    assign m_axi.ARADDR  = r_addr;
    assign m_axi.ARLEN   = 4'd0;
    assign m_axi.ARSIZE  = r_size;
    assign m_axi.ARBURST = 2'b01;
    assign m_axi.RREADY  = w_rd_data & s_axi.RREADY;

    assign m_axi.AWVALID = (r_state == WR_ADDR);
    assign m_axi.AWID    = r_id;
    assign m_axi.AWADDR  = r_addr;
    assign m_axi.AWLEN   = 4'd0;
    assign m_axi.AWSIZE  = r_size;
    assign m_axi.AWBURST = 2'b01;

    assign m_axi.WVALID  = w_wr_data & s_axi.WVALID;
    assign m_axi.WDATA   = w_wr_data ? s_axi.WDATA : '0;
    assign m_axi.WSTRB   = w_wr_data ? s_axi.WSTRB : '0;
    assign m_axi.WLAST   = w_wr_data;

    assign m_axi.BREADY  = (r_state == WR_RESP);
endmodule

// File: tb/tb_dram_burst_splitter.sv
// tb/tb_dram_burst_splitter.sv - directed self-checking bench for dram_burst_splitter
module tb_dram_burst_splitter;
    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 ACLK = ~ACLK;

    dram_burst_splitter_if #(.IDW(IDW), .AW(AW), .DW(DW)) s_if ();
    dram_burst_splitter_if #(.IDW(IDW), .AW(AW), .DW(DW)) m_if ();

    dram_burst_splitter #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s_axi   (s_if),
        .m_axi   (m_if)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic init_inputs();
        s_if.ARID = '0; s_if.ARADDR = '0; s_if.ARLEN = '0; s_if.ARSIZE = '0; s_if.ARBURST = '0; s_if.ARVALID = 1'b0;
        s_if.RREADY = 1'b0;
        s_if.AWID = '0; s_if.AWADDR = '0; s_if.AWLEN = '0; s_if.AWSIZE = '0; s_if.AWBURST = '0; s_if.AWVALID = 1'b0;
        s_if.WDATA = '0; s_if.WSTRB = '0; s_if.WLAST = 1'b0; s_if.WVALID = 1'b0;
        s_if.BREADY = 1'b0;
        m_if.ARREADY = 1'b0;
        m_if.RID = '0; m_if.RDATA = '0; m_if.RRESP = '0; m_if.RLAST = 1'b0; m_if.RVALID = 1'b0;
        m_if.AWREADY = 1'b0;
        m_if.WREADY = 1'b0;
        m_if.BID = '0; m_if.BRESP = '0; m_if.BVALID = 1'b0;
    endtask

    function automatic logic [9:0] handshake_outs();
        return {s_if.ARREADY, s_if.RVALID, s_if.AWREADY, s_if.WREADY, s_if.BVALID,
                m_if.ARVALID, m_if.RREADY, m_if.AWVALID, m_if.WVALID, m_if.BREADY};
    endfunction

    task automatic test_reset();
        init_inputs();
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        checks++;
        if (handshake_outs() !== 10'b0) begin
            errors++;
            $display("FAIL reset_valid_ready: got %b exp %b", handshake_outs(), 10'b0);
        end
        checks++;
        if ({s_if.RLAST, s_if.RID, s_if.BID, s_if.BRESP} !== 19'b0) begin
            errors++;
            $display("FAIL reset_s_fields: got %h exp 0", {s_if.RLAST, s_if.RID, s_if.BID, s_if.BRESP});
        end
        ARESETn = 1'b1;
    endtask

    task automatic test_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int stall);
        logic [31:0] exp_addr;
        logic [31:0] data;
        @(negedge ACLK);
        s_if.ARVALID = 1'b1; s_if.ARID = id; s_if.ARADDR = addr; s_if.ARLEN = len;
        s_if.ARSIZE = 3'd2; s_if.ARBURST = burst;
        #1;
        checks++;
        if (s_if.ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL rd_arready id=%h: got %b exp 1", id, s_if.ARREADY);
        end
        @(negedge ACLK);
        s_if.ARVALID = 1'b0;
        exp_addr = addr;
        for (int b = 0; b <= int'(len); b++) begin
            m_if.ARREADY = 1'b1;
            #1;
            checks++;
            if ({m_if.ARVALID, m_if.ARADDR, m_if.ARLEN, m_if.ARID, m_if.ARSIZE, m_if.ARBURST} !==
                {1'b1, exp_addr, 4'd0, id, 3'd2, 2'b01}) begin
                errors++;
                $display("FAIL rd_m_ar id=%h beat %0d: got v=%b addr=%h len=%h id=%h exp addr=%h len=0 id=%h",
                         id, b, m_if.ARVALID, m_if.ARADDR, m_if.ARLEN, m_if.ARID, exp_addr, id);
            end
            @(negedge ACLK);
            m_if.ARREADY = 1'b0;
            data = 32'hC0DE_0000 + b;
            m_if.RVALID = 1'b1; m_if.RDATA = data; m_if.RRESP = 2'b00; m_if.RLAST = 1'b1;
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    s_if.RREADY = 1'b0;
                    #1;
                    checks++;
                    if ({s_if.RVALID, s_if.RDATA, m_if.RREADY} !== {1'b1, data, 1'b0}) begin
                        errors++;
                        $display("FAIL rd_stall cycle %0d: got v=%b data=%h mrr=%b exp v=1 data=%h mrr=0",
                                 s, s_if.RVALID, s_if.RDATA, m_if.RREADY, data);
                    end
                    @(negedge ACLK);
                end
            end
            s_if.RREADY = 1'b1;
            #1;
            checks++;
            if ({s_if.RVALID, s_if.RDATA, s_if.RID, s_if.RLAST, m_if.RREADY} !==
                {1'b1, data, id, (b == int'(len)), 1'b1}) begin
                errors++;
                $display("FAIL rd_s_r id=%h beat %0d: got v=%b data=%h id=%h last=%b exp data=%h id=%h last=%b",
                         id, b, s_if.RVALID, s_if.RDATA, s_if.RID, s_if.RLAST, data, id, (b == int'(len)));
            end
            @(negedge ACLK);
            m_if.RVALID = 1'b0; m_if.RLAST = 1'b0; s_if.RREADY = 1'b0;
            if (burst != 2'b00) exp_addr = exp_addr + 32'd4;
        end
        #1;
        checks++;
        if ({s_if.RVALID, m_if.ARVALID} !== 2'b00) begin
            errors++;
            $display("FAIL rd_end_idle id=%h: got rvalid=%b arvalid=%b exp 0 0", id, s_if.RVALID, m_if.ARVALID);
        end
    endtask

    task automatic test_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input int wlast_beat, input int err_beat, input int exp_beats,
                              input logic [1:0] exp_bresp);
        logic [31:0] exp_addr;
        logic [31:0] data;
        @(negedge ACLK);
        s_if.AWVALID = 1'b1; s_if.AWID = id; s_if.AWADDR = addr; s_if.AWLEN = len;
        s_if.AWSIZE = 3'd2; s_if.AWBURST = 2'b01;
        #1;
        checks++;
        if (s_if.AWREADY !== 1'b1) begin
            errors++;
            $display("FAIL wr_awready id=%h: got %b exp 1", id, s_if.AWREADY);
        end
        @(negedge ACLK);
        s_if.AWVALID = 1'b0;
        exp_addr = addr;
        for (int b = 0; b < exp_beats; b++) begin
            m_if.AWREADY = 1'b1;
            #1;
            checks++;
            if ({m_if.AWVALID, m_if.AWADDR, m_if.AWLEN, m_if.AWID, s_if.BVALID} !== {1'b1, exp_addr, 4'd0, id, 1'b0}) begin
                errors++;
                $display("FAIL wr_m_aw id=%h beat %0d: got v=%b addr=%h len=%h id=%h bvalid=%b exp addr=%h",
                         id, b, m_if.AWVALID, m_if.AWADDR, m_if.AWLEN, m_if.AWID, s_if.BVALID, exp_addr);
            end
            @(negedge ACLK);
            m_if.AWREADY = 1'b0;
            data = (b % 2 == 1) ? 32'h5A5A5A5A : 32'hA5A5A5A5;
            s_if.WVALID = 1'b1; s_if.WDATA = data; s_if.WSTRB = 4'hF; s_if.WLAST = (b == wlast_beat);
            m_if.WREADY = 1'b1;
            #1;
            checks++;
            if ({m_if.WVALID, m_if.WDATA, m_if.WSTRB, m_if.WLAST, s_if.WREADY} !== {1'b1, data, 4'hF, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL wr_m_w id=%h beat %0d: got v=%b data=%h strb=%h last=%b wready=%b exp data=%h",
                         id, b, m_if.WVALID, m_if.WDATA, m_if.WSTRB, m_if.WLAST, s_if.WREADY, data);
            end
            @(negedge ACLK);
            s_if.WVALID = 1'b0; s_if.WLAST = 1'b0; m_if.WREADY = 1'b0;
            m_if.BVALID = 1'b1; m_if.BRESP = (b == err_beat) ? 2'b10 : 2'b00;
            #1;
            checks++;
            if (m_if.BREADY !== 1'b1) begin
                errors++;
                $display("FAIL wr_m_bready id=%h beat %0d: got %b exp 1", id, b, m_if.BREADY);
            end
            @(negedge ACLK);
            m_if.BVALID = 1'b0; m_if.BRESP = 2'b00;
            exp_addr = exp_addr + 32'd4;
        end
        s_if.BREADY = 1'b1;
        #1;
        checks++;
        if ({s_if.BVALID, s_if.BID, s_if.BRESP, m_if.AWVALID} !== {1'b1, id, exp_bresp, 1'b0}) begin
            errors++;
            $display("FAIL wr_s_b id=%h: got v=%b id=%h resp=%b awvalid=%b exp v=1 id=%h resp=%b awvalid=0",
                     id, s_if.BVALID, s_if.BID, s_if.BRESP, m_if.AWVALID, id, exp_bresp);
        end
        @(negedge ACLK);
        s_if.BREADY = 1'b0;
        #1;
        checks++;
        if (s_if.BVALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_b_single id=%h: got bvalid=%b exp 0", id, s_if.BVALID);
        end
    endtask

    task automatic test_priority();
        @(negedge ACLK);
        s_if.AWVALID = 1'b1; s_if.AWID = 8'h61; s_if.AWADDR = 32'h7000; s_if.AWLEN = 4'd0;
        s_if.AWSIZE = 3'd2; s_if.AWBURST = 2'b01;
        s_if.ARVALID = 1'b1; s_if.ARID = 8'h62; s_if.ARADDR = 32'h8000; s_if.ARLEN = 4'd0;
        s_if.ARSIZE = 3'd2; s_if.ARBURST = 2'b01;
        #1;
        checks++;
        if ({s_if.AWREADY, s_if.ARREADY} !== 2'b10) begin
            errors++;
            $display("FAIL prio_ready: got awready=%b arready=%b exp 1 0", s_if.AWREADY, s_if.ARREADY);
        end
        @(negedge ACLK);
        s_if.AWVALID = 1'b0;
        m_if.AWREADY = 1'b1;
        #1;
        checks++;
        if ({m_if.AWVALID, m_if.AWADDR, s_if.ARREADY, m_if.ARVALID} !== {1'b1, 32'h7000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL prio_aw: got awv=%b addr=%h arready=%b arv=%b exp 1 7000 0 0",
                     m_if.AWVALID, m_if.AWADDR, s_if.ARREADY, m_if.ARVALID);
        end
        @(negedge ACLK);
        m_if.AWREADY = 1'b0;
        s_if.WVALID = 1'b1; s_if.WDATA = 32'h1234_5678; s_if.WSTRB = 4'hF; s_if.WLAST = 1'b1;
        m_if.WREADY = 1'b1;
        @(negedge ACLK);
        s_if.WVALID = 1'b0; s_if.WLAST = 1'b0; m_if.WREADY = 1'b0;
        m_if.BVALID = 1'b1;
        @(negedge ACLK);
        m_if.BVALID = 1'b0;
        s_if.BREADY = 1'b1;
        #1;
        checks++;
        if ({s_if.BVALID, s_if.BID, s_if.BRESP, s_if.ARREADY} !== {1'b1, 8'h61, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL prio_b: got v=%b id=%h resp=%b arready=%b exp 1 61 00 0",
                     s_if.BVALID, s_if.BID, s_if.BRESP, s_if.ARREADY);
        end
        @(negedge ACLK);
        s_if.BREADY = 1'b0;
        #1;
        checks++;
        if (s_if.ARREADY !== 1'b1) begin
            errors++;
            $display("FAIL prio_ar_after_b: got arready=%b exp 1", s_if.ARREADY);
        end
        @(negedge ACLK);
        s_if.ARVALID = 1'b0;
        m_if.ARREADY = 1'b1;
        #1;
        checks++;
        if ({m_if.ARVALID, m_if.ARADDR, m_if.ARID} !== {1'b1, 32'h8000, 8'h62}) begin
            errors++;
            $display("FAIL prio_m_ar: got v=%b addr=%h id=%h exp 1 8000 62", m_if.ARVALID, m_if.ARADDR, m_if.ARID);
        end
        @(negedge ACLK);
        m_if.ARREADY = 1'b0;
        m_if.RVALID = 1'b1; m_if.RDATA = 32'h0000_BEEF; s_if.RREADY = 1'b1;
        #1;
        checks++;
        if ({s_if.RVALID, s_if.RDATA, s_if.RID, s_if.RLAST} !== {1'b1, 32'h0000_BEEF, 8'h62, 1'b1}) begin
            errors++;
            $display("FAIL prio_s_r: got v=%b data=%h id=%h last=%b exp 1 0000beef 62 1",
                     s_if.RVALID, s_if.RDATA, s_if.RID, s_if.RLAST);
        end
        @(negedge ACLK);
        m_if.RVALID = 1'b0; s_if.RREADY = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge ACLK);
        s_if.ARVALID = 1'b1; s_if.ARID = 8'h77; s_if.ARADDR = 32'h9000; s_if.ARLEN = 4'd3;
        s_if.ARSIZE = 3'd2; s_if.ARBURST = 2'b01;
        @(negedge ACLK);
        s_if.ARVALID = 1'b0;
        m_if.ARREADY = 1'b1;
        @(negedge ACLK);
        m_if.ARREADY = 1'b0;
        m_if.RVALID = 1'b1; m_if.RDATA = 32'h1; s_if.RREADY = 1'b1;
        @(negedge ACLK);
        m_if.RVALID = 1'b0; s_if.RREADY = 1'b0;
        m_if.ARREADY = 1'b1;
        @(negedge ACLK);
        m_if.ARREADY = 1'b0;
        m_if.RVALID = 1'b1; m_if.RDATA = 32'h2; m_if.RLAST = 1'b1;
        #1;
        checks++;
        if ({s_if.RVALID, s_if.RLAST, s_if.RDATA} !== {1'b1, 1'b0, 32'h2}) begin
            errors++;
            $display("FAIL rst_pre_beat1: got v=%b last=%b data=%h exp 1 0 00000002", s_if.RVALID, s_if.RLAST, s_if.RDATA);
        end
        ARESETn = 1'b0;
        @(negedge ACLK);
        #1;
        checks++;
        if ({handshake_outs(), s_if.RLAST} !== 11'b0) begin
            errors++;
            $display("FAIL rst_mid_burst: got %b exp 0", {handshake_outs(), s_if.RLAST});
        end
        m_if.RVALID = 1'b0; m_if.RLAST = 1'b0;
        ARESETn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_read(8'h12, 32'h0000_1000, 4'd3, 2'b01, 0);
        test_write(8'h21, 32'h0000_2000, 4'd1, 1, -1, 2, 2'b00);
        test_priority();
        test_read(8'h07, 32'h0000_3000, 4'd2, 2'b00, 5);
        test_write(8'h33, 32'h0000_4000, 4'd3, 1, -1, 2, 2'b10);
        test_write(8'h44, 32'h0000_5000, 4'd3, 3, 1, 4, 2'b10);
        test_write(8'h55, 32'h0000_6000, 4'd1, -1, -1, 2, 2'b10);
        test_read(8'h09, 32'hFFFF_FFFC, 4'd1, 2'b01, 0);
        test_read(8'h0A, 32'h0000_0100, 4'd1, 2'b10, 0);
        test_reset_mid_burst();
        test_read(8'h3C, 32'h0000_A000, 4'd1, 2'b01, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_burst_splitter.md
Name: dram_burst_splitter

Overview:
- Sits directly upstream of the DRAM AXI wrapper, between the AXI interconnect slave port and the wrapper.
- Accepts AXI4 read and write bursts of up to 16 beats and reissues each beat as an independent single-beat transaction (LEN=0) to the wrapper.
- Merges the per-beat responses into one compliant burst response: read data forwarded with the correct RLAST, and a single B response per write burst.

Parameters:
- IDW, 8, AXI ID width
- AW, 32, address width
- DW, 32, data width (STRB = DW/8)

Ports:
- ACLK in 1: clock
- ARESETn in 1: synchronous active-low reset
- S_AR{ID,ADDR,LEN,SIZE,BURST,VALID} in IDW/AW/4/3/2/1, S_ARREADY out 1: upstream read address
- S_R{ID,DATA,RESP,LAST,VALID} out IDW/DW/2/1/1, S_RREADY in 1: upstream read data
- S_AW{ID,ADDR,LEN,SIZE,BURST,VALID} in IDW/AW/4/3/2/1, S_AWREADY out 1: upstream write address
- S_W{DATA,STRB,LAST,VALID} in DW/DW/8/1/1, S_WREADY out 1: upstream write data
- S_B{ID,RESP,VALID} out IDW/2/1, S_BREADY in 1: upstream write response
- M_AR{ID,ADDR,LEN,SIZE,BURST,VALID} out, M_ARREADY in: to wrapper, same widths
- M_R{ID,DATA,RESP,LAST,VALID} in, M_RREADY out
- M_AW{ID,ADDR,LEN,SIZE,BURST,VALID} out, M_AWREADY in
- M_W{DATA,STRB,LAST,VALID} out, M_WREADY in
- M_B{ID,RESP,VALID} in, M_BREADY out

Behaviour:
- Reset: ARESETn sampled on posedge ACLK. All VALID/READY outputs 0, all registers 0, FSM to IDLE. Reset mid-burst abandons the burst; no response is emitted.
- Registered context: id, addr, len, size, burst, beat counter (4b), accumulated BRESP (2b).
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, WR_BACK.
- IDLE:
  - S_AWREADY = S_AWVALID.
  - S_ARREADY = S_ARVALID & !S_AWVALID, so write has priority on simultaneous requests.
  - On accept, latch the context, clear the counter, go to WR_ADDR or RD_ADDR.
- RD_ADDR:
  - M_ARVALID=1 with ADDR=cur addr, LEN=0, SIZE=latched, BURST=INCR, ID=latched.
  - Go to RD_DATA on M_ARREADY.
  - Timing: first M_ARVALID appears one cycle after S_AR handshake.
- RD_DATA (combinational pass-through):
  - S_RVALID=M_RVALID, M_RREADY=S_RREADY, S_RDATA=M_RDATA, S_RRESP=M_RRESP, S_RID=latched id.
  - S_RLAST = (counter==len). M_RLAST is ignored.
  - On handshake: if counter==len go to IDLE; else counter+1, advance addr, go to RD_ADDR.
- Address advance:
  - INCR and WRAP: addr + (1<<SIZE), 32-bit wrap-around.
  - FIXED: addr unchanged.
- WR_ADDR: M_AWVALID=1 with fields as for reads. Go to WR_DATA on M_AWREADY.
- WR_DATA:
  - M_WVALID=S_WVALID, S_WREADY=M_WREADY, M_WDATA/M_WSTRB pass through, M_WLAST=1.
  - On handshake go to WR_RESP.
- WR_RESP:
  - M_BREADY=1. On M_BVALID, accum |= M_BRESP.
  - Go to WR_BACK if this was the final beat: counter==len, or the last data beat had S_WLAST=1.
  - Otherwise counter+1, advance addr, go to WR_ADDR.
- Early/late WLAST:
  - S_WLAST=1 with counter<len ends the burst.
  - counter==len with S_WLAST=0 still ends the burst.
  - In both cases S_BRESP is forced to SLVERR (2'b10).
- WR_BACK: S_BVALID=1, S_BID=latched id, S_BRESP=accum (or SLVERR per above). Go to IDLE on S_BREADY.
- No new S_AR/S_AW is accepted outside IDLE. One outstanding burst total.
- All S_* outputs not driven by the current state are 0.

Test Plan:
- Read LEN=3, SIZE=2, INCR, ADDR=0x0000_1000, ID=0x12 -> four M_AR with addresses 0x1000/0x1004/0x1008/0x100C, each LEN=0. Four S_R beats with RID=0x12; RLAST only on the 4th beat.
- Write LEN=1, ADDR=0x2000, data 0xA5A5A5A5, 0x5A5A5A5A, WSTRB=0xF -> two M_AW (0x2000, 0x2004), each with M_WLAST=1. One S_B with BRESP=00 after the second M_B.
- Simultaneous S_AWVALID and S_ARVALID in IDLE -> S_AWREADY=1 and S_ARREADY=0. The read is accepted in the cycle after S_B handshakes.
- FIXED read LEN=2, ADDR=0x3000 -> all three M_ARADDR=0x3000. With S_RREADY held low for 5 cycles, S_RVALID and S_RDATA stay stable.
- Write LEN=3 with S_WLAST on beat 2 -> only 2 M_AW issued, S_BRESP=10. A separate burst where the 2nd M_BRESP=10 -> S_BRESP=10.
- ARESETn low during RD_DATA of beat 1 -> next cycle all VALID/READY outputs=0, FSM in IDLE, no S_RLAST emitted; the next burst is serviced normally.
